// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and long-latency writebacks,
// and tracks registers with pending long-latency results so decode can stall on them.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ext_issue_i,
    input  logic [4:0]  ext_issue_rd_i,
    input  logic        alu_wb_valid_i,
    input  logic [4:0]  alu_wb_rd_i,
    input  logic [31:0] alu_wb_data_i,
    output logic        alu_wb_ready_o,
    input  logic        ext_wb_valid_i,
    input  logic [4:0]  ext_wb_rd_i,
    input  logic [31:0] ext_wb_data_i,
    output logic        ext_wb_ready_o,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    output logic        hazard_stall_o,
    output logic        rf_write_en_o,
    output logic [4:0]  rf_rd_addr_o,
    output logic [31:0] rf_rd_data_o
);

    typedef enum logic [0:0] {
        ALU_PRIO = 1'b0,
        EXT_PRIO = 1'b1
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] busy_q, busy_d;
    logic        rf_write_en_q;
    logic [4:0]  rf_rd_addr_q;
    logic [31:0] rf_rd_data_q;
    logic        wb_src_ext_q;
    logic        alu_gnt_s, ext_gnt_s;
    logic [4:0]  win_rd_s;
    logic [31:0] win_data_s;

    // Grant selection, starvation counter and priority-state next-state logic
    always_comb begin
        alu_gnt_s    = 1'b0;
        ext_gnt_s    = 1'b0;
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            EXT_PRIO: begin
                ext_gnt_s = ext_wb_valid_i;
                alu_gnt_s = alu_wb_valid_i & ~ext_wb_valid_i;
            end
            ALU_PRIO: begin
                alu_gnt_s = alu_wb_valid_i;
                ext_gnt_s = ext_wb_valid_i & ~alu_wb_valid_i;
            end
            default: begin
                alu_gnt_s = alu_wb_valid_i;
                ext_gnt_s = ext_wb_valid_i & ~alu_wb_valid_i;
            end
        endcase

        if (ext_gnt_s) begin
            starve_cnt_d = 4'd0;
        end else if (ext_wb_valid_i && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        case (state_q)
            ALU_PRIO: begin
                if (starve_cnt_d == LIMIT) begin
                    state_d = EXT_PRIO;
                end else begin
                    state_d = ALU_PRIO;
                end
            end
            EXT_PRIO: begin
                if (ext_gnt_s) begin
                    state_d = ALU_PRIO;
                end else begin
                    state_d = EXT_PRIO;
                end
            end
            default: state_d = ALU_PRIO;
        endcase
    end

    assign win_rd_s   = ext_gnt_s ? ext_wb_rd_i   : alu_wb_rd_i;
    assign win_data_s = ext_gnt_s ? ext_wb_data_i : alu_wb_data_i;

    // Scoreboard update: the clear tracks the committing write, a same-edge issue re-sets the bit
    always_comb begin
        busy_d = busy_q;
        if (rf_write_en_q && wb_src_ext_q) begin
            busy_d[rf_rd_addr_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (ext_issue_i && (ext_issue_rd_i != 5'd0)) begin
            busy_d[ext_issue_rd_i] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // State, scoreboard and registered write-port outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ALU_PRIO;
            starve_cnt_q  <= 4'd0;
            busy_q        <= 32'd0;
            rf_write_en_q <= 1'b0;
            rf_rd_addr_q  <= 5'd0;
            rf_rd_data_q  <= 32'd0;
            wb_src_ext_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            busy_q       <= busy_d;
            if (alu_gnt_s || ext_gnt_s) begin
                rf_write_en_q <= (win_rd_s != 5'd0);
                rf_rd_addr_q  <= win_rd_s;
                rf_rd_data_q  <= win_data_s;
                wb_src_ext_q  <= ext_gnt_s;
            end else begin
                rf_write_en_q <= 1'b0;
            end
        end
    end

    assign alu_wb_ready_o = alu_gnt_s;
    assign ext_wb_ready_o = ext_gnt_s;
    assign hazard_stall_o = busy_q[dec_rs1_i] | busy_q[dec_rs2_i] | busy_q[dec_rd_i];
    assign rf_write_en_o  = rf_write_en_q;
    assign rf_rd_addr_o   = rf_rd_addr_q;
    assign rf_rd_data_o   = rf_rd_data_q;

endmodule
